cpu_core_ctrl: RTL and testbench

CPU_CORE_CTRL -- requirements
Module: cpu_core_ctrl

---
 rtl/cpu_core_ctrl.sv | 153 +++++++++++++++
 tb/tb_cpu_core_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_ctrl.sv
// Multi-cycle 8-register CPU control core: IDLE -> FETCH -> DECODE -> EXECUTE, with HALT.
// Optional BRA instruction (opcode 1110) is enabled by defining CPU_CORE_CTRL_BRANCH_EN.
module cpu_core_ctrl #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        flags,
  output logic              halted,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] regs [8];
  logic [15:0]       ir;
  logic [DATA_W-1:0] op_a, op_b;

  logic [1:0] cond;
  logic [3:0] opcode;
  logic [2:0] dest;
  logic [3:0] shamt;
  assign cond   = ir[15:14];
  assign opcode = ir[13:10];
  assign dest   = ir[9:7];
  assign shamt  = ir[3:0];

  logic              cond_pass;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              wr_en, flag_en, halt_ex;
  logic [PC_W-1:0]   pc_nxt;
  logic [DATA_W:0]   sum, diff, shl_w, shr_w;
`ifdef CPU_CORE_CTRL_BRANCH_EN
  logic [PC_W-1:0]   bra_off;
`endif

  assign sum   = {1'b0, op_a} + {1'b0, op_b};
  assign diff  = {1'b0, op_a} - {1'b0, op_b};
  // The extra bit on each shift catches the last bit pushed out of the word.
  assign shl_w = {1'b0, op_a} << shamt;
  assign shr_w = {op_a, 1'b0} >> shamt;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      2'b00: cond_pass = 1'b1;
      2'b01: cond_pass = flags[0];
      2'b10: cond_pass = ~flags[0];
      2'b11: cond_pass = flags[2];
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    halt_ex = 1'b0;
    pc_nxt  = pc + PC_W'(1);
`ifdef CPU_CORE_CTRL_BRANCH_EN
    bra_off = '0;
    for (int i = 0; i < PC_W; i++) bra_off[i] = ir[(i < 10) ? i : 9];
`endif
    case (opcode)
      4'h1: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];   wr_en = 1'b1; flag_en = 1'b1; end
      4'h2: begin alu_res = diff[DATA_W-1:0]; alu_c = ~diff[DATA_W]; wr_en = 1'b1; flag_en = 1'b1; end
      4'h3: begin alu_res = op_a & op_b; wr_en = 1'b1; flag_en = 1'b1; end
      4'h4: begin alu_res = op_a | op_b; wr_en = 1'b1; flag_en = 1'b1; end
      4'h5: begin alu_res = op_a ^ op_b; wr_en = 1'b1; flag_en = 1'b1; end
      4'h6: begin alu_res = ~op_a;       wr_en = 1'b1; flag_en = 1'b1; end
      4'h7: begin alu_res = op_a;        wr_en = 1'b1; flag_en = 1'b1; end
      4'h8: begin alu_res = shl_w[DATA_W-1:0]; alu_c = shl_w[DATA_W]; wr_en = 1'b1; flag_en = 1'b1; end
      4'h9: begin alu_res = diff[DATA_W-1:0];  alu_c = ~diff[DATA_W]; flag_en = 1'b1; end
      4'hA: begin alu_res = shr_w[DATA_W:1];   alu_c = shr_w[0];      wr_en = 1'b1; flag_en = 1'b1; end
      4'hB: begin alu_res = {{(DATA_W-7){1'b0}}, ir[6:0]}; wr_en = 1'b1; end
`ifdef CPU_CORE_CTRL_BRANCH_EN
      4'hE: pc_nxt = pc + bra_off;
`endif
      4'hF: halt_ex = 1'b1;
      default: ;
    endcase
    // A failed condition turns any instruction into a plain pc increment.
    if (!cond_pass) begin
      wr_en   = 1'b0;
      flag_en = 1'b0;
      halt_ex = 1'b0;
      pc_nxt  = pc + PC_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (run) state_nxt = S_FETCH;
      S_FETCH:   if (imem_ack) state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = halt_ex ? S_HALT : S_FETCH;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pc    <= '0;
      flags <= '0;
      ir    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) ir <= imem_data;
      if (state == S_DECODE) begin
        op_a <= regs[ir[6:4]];
        op_b <= regs[ir[3:1]];
      end
      if (state == S_EXECUTE) begin
        if (!halt_ex) pc <= pc_nxt;
        if (wr_en) regs[dest] <= alu_res;
        if (flag_en) flags <= {alu_res[DATA_W-1], alu_c, (alu_res == '0)};
      end
    end
  end

  // Fetch handshake: request and address stay constant for as long as the
  // block sits in FETCH; the ack cycle is the last cycle of the request.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign dbg_data  = regs[dbg_sel];
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_core_ctrl.sv
// Directed bench for cpu_core_ctrl: a default-size core with a delay-configurable
// instruction memory plus a DATA_W=8 / PC_W=3 core for wrap boundaries.
module tb_cpu_core_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, run, force_ack;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  logic        imem_req, imem_ack, halted;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_data, dbg_data;
  logic [2:0]  flags, dbg_sel, dbg_state;
  logic [15:0] prog [256];

  logic        req_s, halted_s;
  logic [2:0]  addr_s, pc_s, flags_s, dbg_sel_s, state_s;
  logic [15:0] data_s;
  logic [7:0]  dbg_data_s;
  logic [15:0] prog_s [8];

  cpu_core_ctrl #(.DATA_W(16), .PC_W(8)) u_dut (
    .clock(clock), .reset_n(reset_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .flags(flags), .halted(halted),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  cpu_core_ctrl #(.DATA_W(8), .PC_W(3)) u_small (
    .clock(clock), .reset_n(reset_n), .run(run),
    .imem_req(req_s), .imem_addr(addr_s), .imem_ack(1'b1), .imem_data(data_s),
    .pc(pc_s), .flags(flags_s), .halted(halted_s),
    .dbg_sel(dbg_sel_s), .dbg_data(dbg_data_s), .dbg_state(state_s)
  );

  assign imem_data = prog[imem_addr];
  assign imem_ack  = force_ack | (imem_req && (wait_cnt >= ack_delay));
  assign data_s    = prog_s[addr_s];

  always @(posedge clock) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  function automatic logic [15:0] ins(input int c, input int op, input int d, input int s1, input int s2);
    return {c[1:0], op[3:0], d[2:0], s1[2:0], s2[3:0]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input int idx, input logic [15:0] exp);
    dbg_sel = idx[2:0];
    #1;
    chk($sformatf("R%0d", idx), dbg_data, exp);
  endtask

  task automatic chk_reg_s(input int idx, input logic [7:0] exp);
    dbg_sel_s = idx[2:0];
    #1;
    chk($sformatf("small_R%0d", idx), dbg_data_s, exp);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    run       = 1'b0;
    force_ack = 1'b0;
    ack_delay = 0;
    step(2);
    reset_n   = 1'b1;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  initial begin
    dbg_sel = 3'd0;
    dbg_sel_s = 3'd0;
    for (int i = 0; i < 8; i++) prog_s[i] = 16'h0000;
    prog_s[0] = ins(0, 11, 1, 0, 0);   // LDI R1,0
    prog_s[1] = ins(0, 6, 1, 1, 0);    // NOT R1,R1 -> 0xFF
    prog_s[2] = ins(0, 11, 2, 0, 1);   // LDI R2,1
    prog_s[3] = ins(0, 1, 3, 1, 4);    // ADD R3,R1,R2 -> 0x00

    // Run 1: arithmetic program, delayed ack, conditions, halt.
    clear_prog();
    prog[0]  = ins(0, 11, 1, 0, 5);    // LDI R1,5
    prog[1]  = ins(0, 11, 2, 0, 3);    // LDI R2,3
    prog[2]  = ins(0, 1, 3, 1, 4);     // ADD R3,R1,R2
    prog[3]  = ins(0, 1, 1, 1, 4);     // ADD R1,R1,R2
    prog[4]  = ins(0, 9, 0, 1, 2);     // CMP R1,R1
    prog[5]  = ins(2, 1, 6, 1, 4);     // (Z=0) ADD R6,R1,R2
    prog[6]  = ins(1, 1, 7, 1, 4);     // (Z=1) ADD R7,R1,R2
    prog[7]  = ins(0, 2, 5, 2, 2);     // SUB R5,R2,R1
    prog[8]  = ins(3, 8, 4, 1, 13);    // (N=1) SHL R4,R1,13
    prog[9]  = ins(0, 10, 4, 5, 1);    // SHR R4,R5,1
    prog[10] = ins(0, 5, 6, 5, 4);     // XOR R6,R5,R2
    prog[11] = ins(1, 15, 0, 0, 0);    // (Z=1) HALT
    prog[12] = ins(0, 15, 0, 0, 0);    // HALT

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_flags", flags, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_state", dbg_state, 0);
    for (int i = 0; i < 8; i++) chk_reg(i, 16'h0000);

    force_ack = 1'b1;
    step(2);
    chk("idle_state", dbg_state, 0);
    chk("idle_req", imem_req, 0);
    chk("idle_pc", pc, 0);

    run = 1'b1;
    step(9);
    chk("add_exec_pc", pc, 2);
    chk("add_exec_state", dbg_state, 3);
    chk_reg(3, 16'h0000);
    step(1);
    chk("add_pc", pc, 3);
    chk("add_flags", flags, 3'b000);
    chk_reg(1, 16'd5);
    chk_reg(2, 16'd3);
    chk_reg(3, 16'd8);

    force_ack = 1'b0;
    ack_delay = 4;
    for (int i = 0; i < 4; i++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 3);
      step(1);
    end
    chk("ack_cycle_ack", imem_ack, 1);
    chk("ack_cycle_addr", imem_addr, 3);
    step(1);
    chk("post_ack_req", imem_req, 0);
    chk("post_ack_state", dbg_state, 2);
    step(2);
    chk_reg(1, 16'd8);
    chk("once_pc", pc, 4);
    ack_delay = 0;

    step(3);
    chk("cmp_flags", flags, 3'b011);
    chk("cmp_pc", pc, 5);
    chk_reg(1, 16'd8);
    step(3);
    chk("skip_pc", pc, 6);
    chk("skip_flags", flags, 3'b011);
    chk_reg(6, 16'h0000);
    step(3);
    chk("z_add_flags", flags, 3'b000);
    chk_reg(7, 16'd11);
    step(3);
    chk("sub_flags", flags, 3'b100);
    chk_reg(5, 16'hFFFB);
    step(3);
    chk("shl_flags", flags, 3'b011);
    chk_reg(4, 16'h0000);
    step(3);
    chk("shr_flags", flags, 3'b010);
    chk_reg(4, 16'h7FFD);
    step(3);
    chk("xor_flags", flags, 3'b100);
    chk_reg(6, 16'hFFF8);
    step(3);
    chk("skip_halt_pc", pc, 12);
    chk("skip_halt_halted", halted, 0);
    step(3);
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 12);
    chk("halt_req", imem_req, 0);
    chk("halt_state", dbg_state, 4);

    do_reset();
    for (int i = 0; i < 8; i++) chk_reg(i, 16'h0000);
    chk("rst2_flags", flags, 0);
    chk("rst2_pc", pc, 0);
    chk("rst2_halted", halted, 0);

    // Run 2: BRA -2 at pc=5.
    clear_prog();
    prog[5] = {2'b00, 4'b1110, 10'h3FE};
    do_reset();
    run = 1'b1;
    step(19);
`ifdef CPU_CORE_CTRL_BRANCH_EN
    chk("bra_pc", pc, 3);
    chk("bra_addr", imem_addr, 3);
`else
    chk("bra_pc", pc, 6);
    chk("bra_addr", imem_addr, 6);
`endif
    chk("bra_req", imem_req, 1);

    // Run 3: HALT at pc=4, small core runs alongside.
    clear_prog();
    prog[4] = ins(0, 15, 0, 0, 0);
    do_reset();
    run = 1'b1;
    step(13);
    chk("h4_pc", pc, 4);
    chk("h4_state", dbg_state, 1);
    chk_reg_s(1, 8'hFF);
    chk_reg_s(3, 8'h00);
    chk("small_flags", flags_s, 3'b011);
    step(3);
    chk("h4_halted", halted, 1);
    chk("h4_halt_pc", pc, 4);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("h4_no_req", imem_req, 0);
      chk("h4_still_halted", halted, 1);
    end
    chk("small_pc7", pc_s, 7);
    step(3);
    chk("small_pc_wrap", pc_s, 0);
    chk("h4_pc_final", pc, 4);

    // Run 4: reset during an outstanding fetch.
    do_reset();
    ack_delay = 10;
    run = 1'b1;
    step(2);
    chk("mid_fetch_req", imem_req, 1);
    chk("mid_fetch_state", dbg_state, 1);
    reset_n = 1'b0;
    step(1);
    chk("rst_fetch_req", imem_req, 0);
    chk("rst_fetch_halted", halted, 0);
    chk("rst_fetch_pc", pc, 0);
    chk("rst_fetch_addr", imem_addr, 0);
    chk("rst_fetch_flags", flags, 0);
    chk("rst_fetch_state", dbg_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
